// File: rtl/rm_counter.sv
// Register-mask counter for LDM/STM and vector element sequencing.
// Retires the lowest set bit of the loaded mask once per completed transfer.
module rm_counter #(
  parameter int NUM_REGS       = 16,
  parameter int BYTES_PER_XFER = 4,
  localparam int IDX_W = $clog2(NUM_REGS),
  localparam int CNT_W = $clog2(NUM_REGS + 1),
  localparam int OFF_W = $clog2(NUM_REGS * BYTES_PER_XFER + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                vec_mode,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic [CNT_W-1:0]    vec_len,
  input  logic                step,
  output logic [IDX_W-1:0]    cur_reg,
  output logic                done,
  output logic                last,
  output logic                busy,
  output logic [CNT_W-1:0]    xfer_count,
  output logic [OFF_W-1:0]    addr_offset,
  output logic                first
);

  // Control protocol: load captures a new operation (and beats step in the
  // same cycle); step retires one element and must only pulse when a
  // transfer actually completed. There is no back-pressure; a step with
  // nothing remaining is dropped.

  logic [NUM_REGS-1:0] remaining;
  logic [CNT_W-1:0]    xfer_q;
  logic [NUM_REGS-1:0] vec_mask;
  logic [IDX_W-1:0]    low_idx;

  // Thermometer mask of the low vec_len bits; lengths above NUM_REGS saturate.
  always_comb begin
    vec_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      vec_mask[i] = (CNT_W'(i) < vec_len);
    end
  end

  // Priority encoder, lowest set index wins; 0 when the mask is empty.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (remaining[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      xfer_q    <= '0;
    end else if (load) begin
      remaining <= vec_mode ? vec_mask : reg_list;
      xfer_q    <= '0;
    end else if (step && (remaining != '0)) begin
      remaining <= remaining & (remaining - NUM_REGS'(1));
      xfer_q    <= xfer_q + CNT_W'(1);
    end
  end

  assign cur_reg     = low_idx;
  assign done        = (remaining == '0);
  assign busy        = ~done;
  assign last        = ~done && ((remaining & (remaining - NUM_REGS'(1))) == '0);
  assign xfer_count  = xfer_q;
  assign addr_offset = OFF_W'(xfer_q) * OFF_W'(BYTES_PER_XFER);
  assign first       = busy && (xfer_q == '0);

endmodule

// File: tb/tb_rm_counter.sv
// Bench for rm_counter: vector table, directed corner sequences and a
// randomized run checked against a queue-of-indices reference model.
module tb_rm_counter;

  logic        clk;
  logic        rst;
  logic        load;
  logic        vec_mode;
  logic [15:0] reg_list;
  logic [4:0]  vec_len;
  logic        step;
  logic [3:0]  cur_reg;
  logic        done;
  logic        last;
  logic        busy;
  logic [4:0]  xfer_count;
  logic [6:0]  addr_offset;
  logic        first;

  int checks;
  int failures;

  rm_counter dut (
    .clk(clk), .rst(rst), .load(load), .vec_mode(vec_mode),
    .reg_list(reg_list), .vec_len(vec_len), .step(step),
    .cur_reg(cur_reg), .done(done), .last(last), .busy(busy),
    .xfer_count(xfer_count), .addr_offset(addr_offset), .first(first)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of register indices still to transfer.
  int exp_q[$];
  int exp_cnt;

  task automatic model_update(input logic r, input logic ld, input logic vm,
                              input logic [15:0] rl, input logic [4:0] vl,
                              input logic st);
    int n;
    if (r) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (ld) begin
      exp_q.delete();
      exp_cnt = 0;
      if (vm) begin
        n = (vl > 16) ? 16 : int'(vl);
        for (int i = 0; i < n; i++) exp_q.push_back(i);
      end else begin
        for (int i = 0; i < 16; i++) if (rl[i]) exp_q.push_back(i);
      end
    end else if (st && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
  endtask

  // Scoreboard: compare every output against the model.
  task automatic check_model(input string name);
    logic [3:0] e_cur;
    logic       e_done, e_last;
    int         e_off;
    e_cur  = (exp_q.size() > 0) ? 4'(exp_q[0]) : 4'd0;
    e_done = (exp_q.size() == 0);
    e_last = (exp_q.size() == 1);
    e_off  = exp_cnt * 4;
    checks++;
    if (cur_reg !== e_cur || done !== e_done || last !== e_last ||
        busy !== !e_done || xfer_count !== 5'(exp_cnt) ||
        addr_offset !== 7'(e_off) || first !== (!e_done && exp_cnt == 0)) begin
      failures++;
      $display("FAIL %s: got cur=%0d done=%0b last=%0b busy=%0b cnt=%0d off=%0d first=%0b; want cur=%0d done=%0b last=%0b busy=%0b cnt=%0d off=%0d first=%0b",
               name, cur_reg, done, last, busy, xfer_count, addr_offset, first,
               e_cur, e_done, e_last, !e_done, exp_cnt, e_off, (!e_done && exp_cnt == 0));
    end
  endtask

  // Driver: apply inputs for one clock, advance the model, check after the edge.
  task automatic drive(input logic r, input logic ld, input logic vm,
                       input logic [15:0] rl, input logic [4:0] vl,
                       input logic st, input string name);
    rst = r; load = ld; vec_mode = vm; reg_list = rl; vec_len = vl; step = st;
    @(posedge clk);
    model_update(r, ld, vm, rl, vl, st);
    #1;
    check_model(name);
  endtask

  task automatic check_val(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic        rst, load, vm, step;
    logic [15:0] rl;
    logic [4:0]  vl;
    logic [3:0]  e_cur;
    logic        e_done, e_last;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ld, input logic vm,
                              input logic [15:0] rl, input logic [4:0] vl,
                              input logic st, input logic [3:0] ec,
                              input logic ed, input logic el, input logic [4:0] en);
    vec_t v;
    v.rst = r; v.load = ld; v.vm = vm; v.rl = rl; v.vl = vl; v.step = st;
    v.e_cur = ec; v.e_done = ed; v.e_last = el; v.e_cnt = en;
    return v;
  endfunction

  initial begin
    logic [10:0] got, want;
    checks = 0;
    failures = 0;
    rst = 1'b1; load = 1'b0; vec_mode = 1'b0; reg_list = '0; vec_len = '0; step = 1'b0;

    //                 rst ld vm rl       vl   st  cur  done last cnt
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0,  0,  0,  1,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  0,  0,  1,   0,   0));
    tbl.push_back(mk(0, 1, 0, 16'h8091, 0,  0,  0,  0,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  4,  0,   0,   1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  7,  0,   0,   2));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 15,  0,   1,   3));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  0,  1,   0,   4));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  0,  1,   0,   4));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  0,  0,  1,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  0,  1,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  0,  1,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  0,  1,   0,   0));
    tbl.push_back(mk(0, 1, 0, 16'h00F0, 0,  0,  4,  0,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  5,  0,   0,   1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  6,  0,   0,   2));
    tbl.push_back(mk(0, 1, 0, 16'h0003, 0,  1,  0,  0,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  1,  0,   1,   1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  0,  1,   0,   2));
    tbl.push_back(mk(0, 1, 1, 16'hFFFF, 0,  0,  0,  1,   0,   0));
    tbl.push_back(mk(0, 1, 1, 16'h0000, 3,  0,  0,  0,   0,   0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1,  1,  0,   0,   1));
    tbl.push_back(mk(0, 1, 1, 16'h0000, 31, 0,  0,  0,   0,   0));
    tbl.push_back(mk(0, 1, 0, 16'h4000, 0,  0, 14,  0,   1,   0));
    tbl.push_back(mk(1, 1, 0, 16'h00FF, 0,  1,  0,  1,   0,   0));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; load = tbl[k].load; vec_mode = tbl[k].vm;
      reg_list = tbl[k].rl; vec_len = tbl[k].vl; step = tbl[k].step;
      @(posedge clk);
      model_update(tbl[k].rst, tbl[k].load, tbl[k].vm, tbl[k].rl, tbl[k].vl, tbl[k].step);
      #1;
      got  = {cur_reg, done, last, busy, first, xfer_count[2:0]};
      want = {tbl[k].e_cur, tbl[k].e_done, tbl[k].e_last, !tbl[k].e_done,
              (!tbl[k].e_done && tbl[k].e_cnt == 0), tbl[k].e_cnt[2:0]};
      checks++;
      if (got !== want || xfer_count !== tbl[k].e_cnt ||
          addr_offset !== 7'(tbl[k].e_cnt * 4)) begin
        failures++;
        $display("FAIL table[%0d]: got %b cnt=%0d off=%0d want %b cnt=%0d off=%0d",
                 k, got, xfer_count, addr_offset, want, tbl[k].e_cnt, tbl[k].e_cnt * 4);
      end
    end

    // Full vector with idle cycles between steps.
    drive(0, 1, 1, 16'h0, 5'd16, 0, "vec16_load");
    for (int i = 0; i < 16; i++) begin
      check_val("vec16_cur", cur_reg, i);
      drive(0, 0, 0, 16'h0, 5'd0, 0, "vec16_idle");
      check_val("vec16_idle_cur", cur_reg, i);
      drive(0, 0, 0, 16'h0, 5'd0, 1, "vec16_step");
    end
    check_val("vec16_cnt", xfer_count, 16);
    check_val("vec16_off", addr_offset, 64);
    check_val("vec16_done", done, 1);
    drive(0, 0, 0, 16'h0, 5'd0, 1, "vec16_nowrap");
    check_val("vec16_nowrap_cnt", xfer_count, 16);

    // 0xFFFF, five steps, then reset with step held.
    drive(0, 1, 0, 16'hFFFF, 5'd0, 0, "full_load");
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 16'h0, 5'd0, 1, "full_step");
    check_val("full_cur5", cur_reg, 5);
    drive(1, 0, 0, 16'h0, 5'd0, 1, "full_rst");
    check_val("full_rst_done", done, 1);
    check_val("full_rst_cnt", xfer_count, 0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, vm, st;
      logic [15:0] rl;
      logic [4:0] vl;
      r  = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 10);
      vm = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       rl = 16'h0000;
        1:       rl = 16'hFFFF;
        default: rl = 16'($urandom);
      endcase
      vl = 5'($urandom_range(0, 31));
      st = ($urandom_range(0, 99) < 60);
      drive(r, ld, vm, rl, vl, st, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
